// File: rtl/iccm_fetch_if.sv
// ICCM read port as seen by the fetch unit: request/address out, 1-cycle rdata/rvalid back.
interface iccm_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  rvalid;

  modport master (output req, addr, we, wmask, wdata, input  rdata, rvalid);
  modport slave  (input  req, addr, we, wmask, wdata, output rdata, rvalid);
endinterface

// File: rtl/iccm_fetch_unit.sv
// Instruction fetch initiator: one-outstanding ICCM reads into a PC-tagged prefetch FIFO,
// with branch redirect that flushes buffered words and discards the in-flight response.
module iccm_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  iccm_fetch_if.master iccm
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
  } fetch_entry_t;

  fetch_entry_t     fifo_q [FIFO_DEPTH];
  fetch_entry_t     head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      fetch_pc_q, inflight_pc_q;
  logic             inflight_q;
  logic             credit, req, drop, push, pop;
  logic             unused_bits;

  // Credit counts the outstanding response so the FIFO can never overflow.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign req       = rst_ni & fetch_en_i & ~branch_i & credit;
  assign drop      = branch_i & inflight_q;
  assign push      = iccm.rvalid & inflight_q & ~drop;
  assign pop       = instr_valid_o & instr_ready_i;

  assign iccm.req   = req;
  assign iccm.addr  = fetch_pc_q[ADDR_WIDTH+1:2];
  assign iccm.we    = 1'b0;
  assign iccm.wmask = 4'h0;
  assign iccm.wdata = 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q    <= BOOT_ADDR;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      inflight_q <= req;
      if (req) inflight_pc_q <= fetch_pc_q;
      if (branch_i) begin
        fetch_pc_q <= {branch_addr_i[31:2], 2'b00};
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (req)  fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push) wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) fifo_q[wr_ptr_q] <= '{rdata: iccm.rdata, pc: inflight_pc_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !branch_i)
      assert (!(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
  end

  assign head          = fifo_q[rd_ptr_q];
  assign instr_valid_o = (count_q != '0);
  assign instr_rdata_o = instr_valid_o ? head.rdata : 32'h0;
  assign instr_addr_o  = instr_valid_o ? head.pc    : 32'h0;

  assign unused_bits = ^{branch_addr_i[1:0], fetch_pc_q[1:0], fetch_pc_q[31:ADDR_WIDTH+2]};
endmodule
